// File: rtl/keccak_msg_feeder.sv
// keccak_msg_feeder
//
// Byte-stream front end for the keccak core. It packs incoming bytes into
// big-endian 32-bit words and hands them to the core's word port. Before each
// message it sends the core a one-cycle reset pulse. When the core raises
// out_ready, it captures the 512-bit digest.
//
// Ports
//   clk, reset                : rising-edge clock, asynchronous active-high reset
//   s_data/s_valid/s_last     : upstream byte stream (s_last marks final byte)
//   s_ready                   : feeder consumes s_data this cycle
//   core_reset                : one-cycle reset pulse to the core per message
//   in/in_ready/is_last/byte_num : word to core; first byte in [31:24]
//   buffer_full               : core cannot accept a word at this edge
//   out/out_ready             : core digest and its valid flag
//   digest/digest_valid       : captured digest and one-cycle update pulse
//
// Every output is a flop. The flag outputs are computed from the next state,
// so they line up with the state they describe and have no input-to-output
// combinational path.

module keccak_msg_feeder #(
    parameter int DIGEST_W = 512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic                core_reset,
    output logic [31:0]         in,
    output logic                in_ready,
    output logic                is_last,
    output logic [1:0]          byte_num,
    input  logic                buffer_full,
    input  logic [DIGEST_W-1:0] out,
    input  logic                out_ready,
    output logic [DIGEST_W-1:0] digest,
    output logic                digest_valid
);

    typedef enum logic [2:0] {
        IDLE,
        CRST,
        FILL,
        SEND,
        FLUSH,
        WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  flush_q, flush_d;
    logic                  s_ready_q, s_ready_d;
    logic                  core_reset_q, core_reset_d;
    logic [31:0]           in_q, in_d;
    logic                  in_ready_q, in_ready_d;
    logic                  is_last_q, is_last_d;
    logic [1:0]            byte_num_q, byte_num_d;
    logic [DIGEST_W-1:0]   digest_q, digest_d;
    logic                  digest_valid_q, digest_valid_d;
    logic                  word_accept;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        flush_d        = flush_q;
        in_d           = in_q;
        is_last_d      = is_last_q;
        byte_num_d     = byte_num_q;
        digest_d       = digest_q;
        digest_valid_d = 1'b0;
        word_accept    = in_ready_q && !buffer_full;

        case (state_q)
            IDLE: begin
                // The byte that wakes us is left in place and consumed in FILL.
                if (s_valid) begin
                    state_d = CRST;
                end
            end
            CRST: begin
                cnt_d      = 2'd0;
                in_d       = 32'd0;
                flush_d    = 1'b0;
                is_last_d  = 1'b0;
                byte_num_d = 2'd0;
                state_d    = FILL;
            end
            FILL: begin
                if (s_valid) begin
                    case (cnt_q)
                        2'd0: in_d[31:24] = s_data;
                        2'd1: in_d[23:16] = s_data;
                        2'd2: in_d[15:8]  = s_data;
                        2'd3: in_d[7:0]   = s_data;
                        default: in_d = in_q;
                    endcase
                    // cnt wraps to 0 after a full word, ready for the next one.
                    cnt_d = cnt_q + 2'd1;
                    if (s_last) begin
                        state_d = SEND;
                        if (cnt_q == 2'd3) begin
                            // A full final word cannot carry byte_num, so an
                            // empty terminator word follows it.
                            flush_d = 1'b1;
                        end else begin
                            is_last_d  = 1'b1;
                            byte_num_d = cnt_q + 2'd1;
                        end
                    end else if (cnt_q == 2'd3) begin
                        state_d = SEND;
                    end
                end
            end
            SEND: begin
                if (word_accept) begin
                    // Clearing here leaves unwritten lanes of the next word at 0
                    // and pre-loads the all-zero flush word.
                    in_d = 32'd0;
                    if (is_last_q) begin
                        state_d    = WAIT;
                        is_last_d  = 1'b0;
                        byte_num_d = 2'd0;
                    end else if (flush_q) begin
                        state_d    = FLUSH;
                        flush_d    = 1'b0;
                        is_last_d  = 1'b1;
                        byte_num_d = 2'd0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FLUSH: begin
                if (word_accept) begin
                    state_d    = WAIT;
                    is_last_d  = 1'b0;
                    byte_num_d = 2'd0;
                end
            end
            WAIT: begin
                if (out_ready) begin
                    digest_d       = out;
                    digest_valid_d = 1'b1;
                    state_d        = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_ready_d    = (state_d == FILL);
        in_ready_d   = (state_d == SEND) || (state_d == FLUSH);
        core_reset_d = (state_d == CRST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= 2'd0;
            flush_q        <= 1'b0;
            s_ready_q      <= 1'b0;
            core_reset_q   <= 1'b0;
            in_q           <= 32'd0;
            in_ready_q     <= 1'b0;
            is_last_q      <= 1'b0;
            byte_num_q     <= 2'd0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            flush_q        <= flush_d;
            s_ready_q      <= s_ready_d;
            core_reset_q   <= core_reset_d;
            in_q           <= in_d;
            in_ready_q     <= in_ready_d;
            is_last_q      <= is_last_d;
            byte_num_q     <= byte_num_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
        end
    end

    assign s_ready      = s_ready_q;
    assign core_reset   = core_reset_q;
    assign in           = in_q;
    assign in_ready     = in_ready_q;
    assign is_last      = is_last_q;
    assign byte_num     = byte_num_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

endmodule

// File: tb/tb_keccak_msg_feeder.sv
// Testbench for keccak_msg_feeder.
//
// The main process drives byte messages. A monitor process acts as the core:
// it applies backpressure and returns a digest. It also checks every word the
// feeder hands over against a word list computed from the message bytes.

module tb_keccak_msg_feeder;

    localparam int W = 512;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_last;
    logic          s_ready;
    logic          core_reset;
    logic [31:0]   in;
    logic          in_ready;
    logic          is_last;
    logic [1:0]    byte_num;
    logic          buffer_full;
    logic [W-1:0]  out;
    logic          out_ready;
    logic [W-1:0]  digest;
    logic          digest_valid;

    always #5 clk = ~clk;

    keccak_msg_feeder #(.DIGEST_W(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .core_reset   (core_reset),
        .in           (in),
        .in_ready     (in_ready),
        .is_last      (is_last),
        .byte_num     (byte_num),
        .buffer_full  (buffer_full),
        .out          (out),
        .out_ready    (out_ready),
        .digest       (digest),
        .digest_valid (digest_valid)
    );

    typedef struct {
        logic [31:0] w;
        logic        last;
        logic [1:0]  bn;
    } exp_t;

    int compared   = 0;
    int mismatched = 0;

    // Written only by the main process.
    string reqMsg;
    int    reqId          = 0;
    bit    reqModel       = 1'b0;
    int    reqStallWord   = 0;
    int    reqStallCycles = 0;

    // Written only by the monitor process.
    exp_t        expQ[$];
    logic [31:0] gotW[$];
    logic        gotL[$];
    logic [1:0]  gotB[$];
    int          seenId          = 0;
    int          crstCount       = 0;
    int          dvCount         = 0;
    int          wordsAccepted   = 0;
    int          pendingMsg      = 0;
    int          stallWord       = 0;
    int          stallLeft       = 0;
    int          stallCyclesSeen = 0;
    int          digestDelay     = -1;
    int          outReadyAge     = 0;
    logic [W-1:0] expDigest      = '0;

    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference word list, derived only from the packing rules. Bytes go in
    // big-endian order into 32-bit words. A short tail is final and carries
    // its byte count. A message whose length is a multiple of 4 gets an
    // extra empty final word.
    task automatic buildWords(input string msg);
        int          n;
        int          k;
        logic [31:0] w;
        exp_t        e;
        n = msg.len();
        for (int i = 0; i < n; i += 4) begin
            k = (n - i < 4) ? (n - i) : 4;
            w = 32'd0;
            for (int j = 0; j < k; j++) begin
                w[31 - 8*j -: 8] = msg[i + j];
            end
            e.w    = w;
            e.last = (k < 4);
            e.bn   = (k < 4) ? 2'(k) : 2'd0;
            expQ.push_back(e);
        end
        if (n % 4 == 0) begin
            e.w    = 32'd0;
            e.last = 1'b1;
            e.bn   = 2'd0;
            expQ.push_back(e);
        end
    endtask

    // Core model and checker. Inputs for the coming edge are decided first at
    // each falling edge. Outputs are then judged against those inputs.
    initial begin : monitor
        exp_t e;
        buffer_full = 1'b0;
        out_ready   = 1'b0;
        out         = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                expQ.delete();
                buffer_full = 1'b0;
                out_ready   = 1'b0;
                stallLeft   = 0;
                digestDelay = -1;
                pendingMsg  = 0;
            end else begin
                if (reqId != seenId) begin
                    seenId = reqId;
                    if (reqModel) buildWords(reqMsg);
                    stallWord = wordsAccepted + reqStallWord;
                    stallLeft = reqStallCycles;
                end
                if (out_ready) outReadyAge++;
                if (core_reset) begin
                    checkOutput("core_reset_after_digest", W'(pendingMsg), W'(0));
                    pendingMsg = 1;
                    crstCount++;
                    out_ready  = 1'b0;
                end
                if (in_ready && stallLeft > 0 && wordsAccepted == stallWord) begin
                    buffer_full = 1'b1;
                    stallLeft--;
                    stallCyclesSeen++;
                    checkOutput("stall_in_held", W'(in), W'(32'h35363738));
                    checkOutput("stall_s_ready", W'(s_ready), W'(0));
                end else begin
                    buffer_full = 1'b0;
                end
                if (in_ready) begin
                    checkOutput("s_ready_low_while_in_ready", W'(s_ready), W'(0));
                    if (!is_last) checkOutput("byte_num_zero_not_last", W'(byte_num), W'(0));
                end
                if (in_ready && !buffer_full) begin
                    checkOutput("word_expected", W'(expQ.size() != 0), W'(1));
                    if (expQ.size() != 0) begin
                        e = expQ.pop_front();
                        checkOutput("word_in", W'(in), W'(e.w));
                        checkOutput("word_is_last", W'(is_last), W'(e.last));
                        checkOutput("word_byte_num", W'(byte_num), W'(e.bn));
                    end
                    gotW.push_back(in);
                    gotL.push_back(is_last);
                    gotB.push_back(byte_num);
                    wordsAccepted++;
                    if (is_last) digestDelay = 3;
                end
                if (digestDelay == 0) begin
                    out         = {16{32'hD1600000 ^ 32'(seenId)}};
                    expDigest   = out;
                    out_ready   = 1'b1;
                    outReadyAge = 0;
                    digestDelay = -1;
                end else if (digestDelay > 0) begin
                    digestDelay--;
                end
                if (digest_valid) begin
                    checkOutput("digest_value", digest, expDigest);
                    checkOutput("digest_latency", W'(outReadyAge), W'(1));
                    pendingMsg = 0;
                    dvCount++;
                end
            end
        end
    end

    // Sends one message byte by byte. If abortAfter > 0, reset is asserted
    // mid-message once that many bytes have been consumed.
    task automatic applyStimulus(input string msg, input bit keepValid, input int abortAfter,
                                 input int stallIdx, input int stallCycles);
        int   n;
        int   i;
        int   budget;
        int   crst0;
        int   dv0;
        logic rdy;
        n = msg.len();
        reqMsg         = msg;
        reqModel       = (abortAfter == 0);
        reqStallWord   = stallIdx;
        reqStallCycles = stallCycles;
        reqId++;
        crst0 = crstCount;
        dv0   = dvCount;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        s_data  = msg[0];
        s_last  = (n == 1);
        i       = 0;
        budget  = 0;
        while (i < n && budget < 400) begin
            @(negedge clk);
            rdy = s_ready;
            @(posedge clk);
            #1;
            budget++;
            if (rdy) begin
                i++;
                if (abortAfter > 0 && i == abortAfter) begin
                    #2;
                    reset = 1'b1;
                    #1;
                    checkOutput("rst_s_ready", W'(s_ready), W'(0));
                    checkOutput("rst_core_reset", W'(core_reset), W'(0));
                    checkOutput("rst_in", W'(in), W'(0));
                    checkOutput("rst_in_ready", W'(in_ready), W'(0));
                    checkOutput("rst_is_last", W'(is_last), W'(0));
                    checkOutput("rst_byte_num", W'(byte_num), W'(0));
                    checkOutput("rst_digest", digest, W'(0));
                    checkOutput("rst_digest_valid", W'(digest_valid), W'(0));
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    repeat (2) @(posedge clk);
                    #1;
                    reset = 1'b0;
                    return;
                end
                if (i < n) begin
                    s_data = msg[i];
                    s_last = (i == n - 1);
                end
            end
        end
        checkOutput("all_bytes_consumed", W'(i), W'(n));
        s_last = 1'b0;
        if (!keepValid) s_valid = 1'b0;
        budget = 0;
        while (dvCount == dv0 && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
            checkOutput("s_ready_low_after_last_byte", W'(s_ready), W'(0));
        end
        checkOutput("digest_pulses", W'(dvCount - dv0), W'(1));
        checkOutput("core_reset_pulses", W'(crstCount - crst0), W'(1));
        checkOutput("words_outstanding", W'(expQ.size()), W'(0));
    endtask

    initial begin : main
        int start;
        reset   = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_s_ready", W'(s_ready), W'(0));
        checkOutput("reset_in_ready", W'(in_ready), W'(0));
        checkOutput("reset_core_reset", W'(core_reset), W'(0));
        checkOutput("reset_digest", digest, W'(0));
        reset = 1'b0;

        $display("[TB] single byte message");
        start = gotW.size();
        applyStimulus("a", 1'b0, 0, 0, 0);
        checkOutput("a_count", W'(gotW.size() - start), W'(1));
        checkOutput("a_word", W'(gotW[start]), W'(32'h61000000));
        checkOutput("a_byte_num", W'(gotB[start]), W'(1));

        $display("[TB] pangram");
        start = gotW.size();
        applyStimulus("The quick brown fox jumps over the lazy dog", 1'b0, 0, 0, 0);
        checkOutput("fox_count", W'(gotW.size() - start), W'(11));
        checkOutput("fox_first", W'(gotW[start]), W'(32'h54686520));
        checkOutput("fox_last_word", W'(gotW[start + 10]), W'(32'h646F6700));
        checkOutput("fox_last_flag", W'(gotL[start + 10]), W'(1));
        checkOutput("fox_byte_num", W'(gotB[start + 10]), W'(3));

        $display("[TB] word-aligned message");
        start = gotW.size();
        applyStimulus("Hello, world", 1'b0, 0, 0, 0);
        checkOutput("hello_count", W'(gotW.size() - start), W'(4));
        checkOutput("hello_w2", W'(gotW[start + 2]), W'(32'h6F726C64));
        checkOutput("hello_w2_last", W'(gotL[start + 2]), W'(0));
        checkOutput("hello_flush_in", W'(gotW[start + 3]), W'(0));
        checkOutput("hello_flush_last", W'(gotL[start + 3]), W'(1));
        checkOutput("hello_flush_bn", W'(gotB[start + 3]), W'(0));

        $display("[TB] backpressure on second word");
        start = stallCyclesSeen;
        applyStimulus("1234567890", 1'b0, 0, 1, 10);
        checkOutput("stall_cycles", W'(stallCyclesSeen - start), W'(10));
        checkOutput("num_w1", W'(gotW[gotW.size() - 2]), W'(32'h35363738));
        checkOutput("num_tail", W'(gotW[gotW.size() - 1]), W'(32'h39300000));
        checkOutput("num_tail_bn", W'(gotB[gotB.size() - 1]), W'(2));

        $display("[TB] reset mid-message");
        applyStimulus("xyzw", 1'b0, 2, 0, 0);
        start = gotW.size();
        applyStimulus("pass", 1'b0, 0, 0, 0);
        checkOutput("pass_count", W'(gotW.size() - start), W'(2));
        checkOutput("pass_word", W'(gotW[start]), W'(32'h70617373));

        $display("[TB] back-to-back messages");
        start = gotW.size();
        applyStimulus("ab", 1'b1, 0, 0, 0);
        applyStimulus("cdefg", 1'b0, 0, 0, 0);
        checkOutput("b2b_count", W'(gotW.size() - start), W'(3));
        checkOutput("b2b_w0", W'(gotW[start]), W'(32'h61620000));
        checkOutput("b2b_w1", W'(gotW[start + 1]), W'(32'h63646566));
        checkOutput("b2b_w2", W'(gotW[start + 2]), W'(32'h67000000));

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #300000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
